stereo_boxcar_decimator: RTL and testbench

- Stereo sample-rate reducer for the audio path: the inverse of the linear interpolator.
- Accumulates every input sample strobed in on `din_en` and, on each `dout_en` request, emits the arithmetic mean of the samples received since the previous request.
- Sits between a fast upstream source (FIR/ADC domain) and a slower output sample clock.
- Division is a shared-iteration sequential restoring divider, so no DSP multiplier is used.

---
 rtl/stereo_boxcar_decimator.sv | 119 +++++++++++
 tb/tb_stereo_boxcar_decimator.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_boxcar_decimator.sv
// stereo_boxcar_decimator: stereo boxcar-mean decimator with a shared restoring divider (optional DECIM_ROUND_EN rounding)
module stereo_boxcar_decimator #(
   parameter int DATA_W = 24,
   parameter int CNT_W  = 8,
   parameter int ACC_W  = DATA_W + CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        din_en,
   input  logic [31:0] l_data_in,
   input  logic [31:0] r_data_in,
   input  logic        dout_en,
   output logic        dout_valid,
   output logic [31:0] l_data_out,
   output logic [31:0] r_data_out,
   output logic        busy,
   output logic        sat_flag
);
   localparam int IT_W = $clog2(ACC_W);
   typedef enum logic [1:0] {S_IDLE, S_DIV, S_OUT} state_t;
   state_t                   r_state, w_next;
   logic                     r_din_dly, r_dout_dly;
   logic signed [ACC_W-1:0]  r_l_acc, r_r_acc;
   logic [CNT_W-1:0]         r_cnt, r_div;
   logic [IT_W-1:0]          r_it;
   logic                     r_l_neg, r_r_neg;
   logic [ACC_W-1:0]         r_l_q, r_r_q;
   logic [CNT_W-1:0]         r_l_rem, r_r_rem;
   logic                     w_din_edge, w_dout_edge, w_start, w_l_ge, w_r_ge;
   logic signed [ACC_W-1:0]  w_l_ext, w_r_ext;
   logic [ACC_W-1:0]         w_l_mag, w_r_mag, w_rnd, w_l_res, w_r_res;
   logic [CNT_W:0]           w_l_sh, w_r_sh;
   assign w_din_edge  = din_en & ~r_din_dly;
   assign w_dout_edge = dout_en & ~r_dout_dly;
   assign w_start     = (r_state == S_IDLE) & w_dout_edge;
   assign busy        = r_state != S_IDLE;
   assign w_l_ext     = ACC_W'($signed(l_data_in[DATA_W-1:0]));
   assign w_r_ext     = ACC_W'($signed(r_data_in[DATA_W-1:0]));
`ifdef DECIM_ROUND_EN
   assign w_rnd       = ACC_W'(r_cnt >> 1);
`else
   assign w_rnd       = '0;
`endif
   assign w_l_mag     = (r_l_acc[ACC_W-1] ? -r_l_acc : r_l_acc) + w_rnd;
   assign w_r_mag     = (r_r_acc[ACC_W-1] ? -r_r_acc : r_r_acc) + w_rnd;
   assign w_l_sh      = {r_l_rem, r_l_q[ACC_W-1]};
   assign w_r_sh      = {r_r_rem, r_r_q[ACC_W-1]};
   assign w_l_ge      = w_l_sh >= {1'b0, r_div};
   assign w_r_ge      = w_r_sh >= {1'b0, r_div};
   assign w_l_res     = r_l_neg ? -r_l_q : r_l_q;
   assign w_r_res     = r_r_neg ? -r_r_q : r_r_q;
   // state register
   always_ff @(posedge clk)
      r_state <= reset ? S_IDLE : w_next;
   // next state: a request starts a division, ACC_W iterations, then one output cycle
   always_comb begin
      w_next = r_state;
      w_next = r_state == S_IDLE ? (w_dout_edge ? S_DIV : S_IDLE)
             : r_state == S_DIV  ? (r_it == '0 ? S_OUT : S_DIV)
             : S_IDLE;
   end
   // accumulation, snapshot, divider iterations and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_din_dly  <= 1'b0;
         r_dout_dly <= 1'b0;
         r_l_acc    <= '0;
         r_r_acc    <= '0;
         r_cnt      <= '0;
         r_div      <= '0;
         r_it       <= '0;
         r_l_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
         r_l_q      <= '0;
         r_r_q      <= '0;
         r_l_rem    <= '0;
         r_r_rem    <= '0;
         sat_flag   <= 1'b0;
         dout_valid <= 1'b0;
         l_data_out <= '0;
         r_data_out <= '0;
      end else begin
         r_din_dly  <= din_en;
         r_dout_dly <= dout_en;
         dout_valid <= r_state == S_OUT;
         if (w_start) begin
            r_l_neg <= r_l_acc[ACC_W-1];
            r_r_neg <= r_r_acc[ACC_W-1];
            r_l_q   <= w_l_mag;
            r_r_q   <= w_r_mag;
            r_l_rem <= '0;
            r_r_rem <= '0;
            r_div   <= r_cnt;
            r_it    <= IT_W'(ACC_W - 1);
            r_l_acc <= w_din_edge ? w_l_ext : '0;
            r_r_acc <= w_din_edge ? w_r_ext : '0;
            r_cnt   <= w_din_edge ? CNT_W'(1) : '0;
         end else if (w_din_edge) begin
            if (r_cnt != '1) begin
               r_l_acc <= r_l_acc + w_l_ext;
               r_r_acc <= r_r_acc + w_r_ext;
               r_cnt   <= r_cnt + 1'b1;
            end else
               sat_flag <= 1'b1;
         end
         if (r_state == S_DIV) begin
            r_l_rem <= CNT_W'(w_l_ge ? w_l_sh - {1'b0, r_div} : w_l_sh);
            r_r_rem <= CNT_W'(w_r_ge ? w_r_sh - {1'b0, r_div} : w_r_sh);
            r_l_q   <= {r_l_q[ACC_W-2:0], w_l_ge};
            r_r_q   <= {r_r_q[ACC_W-2:0], w_r_ge};
            r_it    <= r_it - 1'b1;
         end
         if (r_state == S_OUT && r_div != '0) begin
            l_data_out <= 32'($signed(w_l_res[DATA_W-1:0]));
            r_data_out <= 32'($signed(w_r_res[DATA_W-1:0]));
         end
      end
   end
endmodule

// File: tb/tb_stereo_boxcar_decimator.sv
// tb_stereo_boxcar_decimator: randomized and directed bench against a mean-of-window reference model
module tb_stereo_boxcar_decimator;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        din_en = 1'b0;
   logic [31:0] l_data_in = '0;
   logic [31:0] r_data_in = '0;
   logic        dout_en = 1'b0;
   logic        dout_valid, busy, sat_flag;
   logic [31:0] l_data_out, r_data_out;
   int          vectors = 0;
   int          miscompares = 0;
`ifdef DECIM_ROUND_EN
   localparam int NEG_EXP = -4;
   localparam int POS_EXP = 6;
`else
   localparam int NEG_EXP = -3;
   localparam int POS_EXP = 5;
`endif

   stereo_boxcar_decimator dut (
      .clk(clk), .reset(reset), .din_en(din_en), .l_data_in(l_data_in), .r_data_in(r_data_in),
      .dout_en(dout_en), .dout_valid(dout_valid), .l_data_out(l_data_out), .r_data_out(r_data_out),
      .busy(busy), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int sx(input logic [31:0] x);
      return int'($signed(x[23:0]));
   endfunction

   function automatic int mean(input longint s, input int n);
      longint m;
      m = s < 0 ? -s : s;
`ifdef DECIM_ROUND_EN
      m = m + n / 2;
`endif
      m = m / n;
      return int'(s < 0 ? -m : m);
   endfunction

   // reference model: window sums, a pending result due 33 clocks after acceptance
   longint m_sl, m_sr;
   int     m_cnt, m_due, m_qc, m_ql, m_qr, m_l, m_r, cyc = 0;
   bit     m_sat, m_pend, m_vout, m_pd, m_pdo, din_e, dout_e, acc;
   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         m_sl = 0; m_sr = 0; m_cnt = 0; m_sat = 0; m_pend = 0; m_vout = 0;
         m_l = 0; m_r = 0; m_pd = 0; m_pdo = 0;
      end else begin
         din_e  = din_en && !m_pd;
         dout_e = dout_en && !m_pdo;
         m_pd   = din_en;
         m_pdo  = dout_en;
         acc    = dout_e && !m_pend;
         m_vout = m_pend && cyc == m_due;
         if (m_vout) begin
            m_pend = 0;
            if (m_qc != 0) begin
               m_l = m_ql;
               m_r = m_qr;
            end
         end
         if (acc) begin
            m_qc = m_cnt;
            if (m_cnt != 0) begin
               m_ql = mean(m_sl, m_cnt);
               m_qr = mean(m_sr, m_cnt);
            end
            m_pend = 1;
            m_due  = cyc + 33;
            m_sl = 0; m_sr = 0; m_cnt = 0;
         end
         if (din_e) begin
            if (m_cnt < 255) begin
               m_sl += sx(l_data_in);
               m_sr += sx(r_data_in);
               m_cnt++;
            end else
               m_sat = 1;
         end
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("dout_valid", 32'(dout_valid), 32'(m_vout));
         chk("busy", 32'(busy), 32'(m_pend));
         chk("sat_flag", 32'(sat_flag), 32'(m_sat));
         chk("l_data_out", l_data_out, m_l);
         chk("r_data_out", r_data_out, m_r);
      end
   end

   task automatic smp(input int l, input int r, input int h);
      din_en = 1'b1;
      l_data_in = {8'($urandom), 24'(l)};
      r_data_in = {8'($urandom), 24'(r)};
      repeat (h) @(negedge clk);
      din_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic wv(output int k);
      k = 0;
      while (k < 80) begin
         @(negedge clk);
         k++;
         if (dout_valid) return;
      end
      vectors++;
      miscompares++;
      $display("FAIL dout_valid_timeout: got no pulse in %0d cycles, required one", k);
   endtask

   task automatic req(output int k, input int h);
      int w;
      dout_en = 1'b1;
      repeat (h) @(negedge clk);
      dout_en = 1'b0;
      wv(w);
      k = w + h;
   endtask

   initial begin
      int k, nv;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_l", l_data_out, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(dout_valid), 32'd0);
      // basic mean with latency
      smp(100, -8, 1); smp(200, -8, 2); smp(300, -8, 1); smp(401, -8, 3);
      req(k, 1);
      chk("basic_latency", k, 34);
      chk("basic_l", l_data_out, 32'd250);
      chk("basic_r", r_data_out, 32'hFFFFFFF8);
      // sign and rounding
      smp(-3, 0, 1); smp(-4, 0, 1);
      req(k, 1);
      chk("neg_l", l_data_out, NEG_EXP);
      smp(5, 0, 1); smp(6, 0, 1);
      req(k, 2);
      chk("pos_l", l_data_out, POS_EXP);
      // saturation and empty window
      for (int i = 0; i < 300; i++) smp(1000, -32'sh800000, 1);
      chk("sat_flag_set", 32'(sat_flag), 32'd1);
      req(k, 1);
      chk("sat_l", l_data_out, 32'd1000);
      chk("sat_r", r_data_out, 32'hFF800000);
      req(k, 1);
      chk("empty_l", l_data_out, 32'd1000);
      chk("empty_r", r_data_out, 32'hFF800000);
      // sample coincident with request belongs to next window
      smp(10, 0, 1); smp(20, 0, 1);
      din_en = 1'b1; l_data_in = 32'd1000; dout_en = 1'b1;
      @(negedge clk);
      din_en = 1'b0; dout_en = 1'b0;
      wv(k);
      chk("coll_l", l_data_out, 32'd15);
      req(k, 1);
      chk("coll_next_l", l_data_out, 32'd1000);
      // second request while busy is ignored
      smp(4, 4, 1);
      nv = 0;
      dout_en = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         dout_en = (i == 10);
         if (dout_valid) nv++;
      end
      chk("busy_single_valid", nv, 1);
      chk("busy_l", l_data_out, 32'd4);
      // reset during division
      smp(50, 50, 1);
      nv = 0;
      dout_en = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         dout_en = 1'b0;
         reset = (i == 10);
         if (dout_valid) nv++;
      end
      chk("rstdiv_no_valid", nv, 0);
      chk("rstdiv_l", l_data_out, 32'd0);
      chk("rstdiv_busy", 32'(busy), 32'd0);
      smp(7, 7, 1); smp(9, 9, 1);
      req(k, 1);
      chk("rstdiv_next_l", l_data_out, 32'd8);
      // randomized windows checked by the model
      for (int w = 0; w < 30; w++) begin
         int n;
         n = $urandom_range(0, 6);
         for (int i = 0; i < n; i++) smp(int'($urandom), int'($urandom), $urandom_range(1, 3));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            din_en = 1'b1; l_data_in = $urandom; r_data_in = $urandom; dout_en = 1'b1;
            @(negedge clk);
            din_en = 1'b0; dout_en = 1'b0;
            wv(k);
         end else
            req(k, $urandom_range(1, 3));
      end
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
